scoreboard_alu: RTL and testbench
=================================

Name: scoreboard_alu

Overview:
- Bench-side checker that pairs with the ALU stimulus driver.
- Samples the same operand/opcode bus the driver produces and the ALU result returned by the DUT.
- Computes the golden result, delays it to match the DUT latency and compares. Keeps pass/fail statistics and captures the first failing transaction for debug.
- Sits in the ALU unit-level bench next to the driver; synthesizable style, no $display dependence.

Parameters:
- LATENCY, 0, DUT pipeline depth in cycles between operand sample and valid i_alu_data (0 = combinational ALU). Range 0..8.
- CNT_W, 32, width of the check and error counters.

Ports:
- i_clk  input  1  bench clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  sample enable; when low, the current cycle inserts a bubble (not checked).
- i_operand_a  input  32  operand A as driven to the DUT.
- i_operand_b  input  32  operand B as driven to the DUT.
- i_alu_op  input  ALUSel_e  opcode as driven to the DUT.
- i_alu_data  input  32  DUT result.
- o_mismatch  output  1  one-cycle pulse: a check failed.
- o_err_flag  output  1  sticky: at least one failure since reset.
- o_check_cnt  output  CNT_W  number of checks performed (saturating).
- o_err_cnt  output  CNT_W  number of failed checks (saturating).
- o_first_op  output  ALUSel_e  opcode of the first failure.
- o_first_a  output  32  operand A of the first failure.
- o_first_b  output  32  operand B of the first failure.
- o_first_exp  output  32  expected result of the first failure.
- o_first_got  output  32  DUT result of the first failure.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; o_first_op = ALU_ADD; all pipeline valid bits 0.
- Sample:
  - Each rising edge with i_en=1 and a supported opcode pushes {valid=1, op, a, b, expected} into stage 0 of a LATENCY-deep shift pipe.
  - Otherwise it pushes valid=0.
- LATENCY=0: the check uses the current-cycle golden result against current i_alu_data.
- Check:
  - A check is performed when the pipe output entry is valid. It is registered: counters, flags and o_mismatch update on the edge after the entry reaches the compare point.
  - o_mismatch is therefore a registered pulse one cycle after the compared sample.
  - Warm-up: the first LATENCY edges after reset produce no checks, because valid bits are 0.
- Golden model (32-bit, wrap-around):
  - ADD: a+b. SUB: a-b.
  - XOR / OR / AND: bitwise.
  - SLL: a<<b[4:0]. SRL: logical a>>b[4:0]. SRA: arithmetic shift by b[4:0].
  - SLT: signed a<b -> 32'd1, else 0. SLTU: unsigned compare.
- Unsupported ALUSel_e encodings: treated as a bubble, never counted.
- Counters:
  - o_check_cnt increments per check.
  - o_err_cnt increments per mismatch.
  - Both saturate at 2^CNT_W-1 with no wrap.
- First-error capture: loaded only on the mismatch that sets o_err_flag from 0 to 1; held until reset.
- Simultaneous events: a mismatch on the edge where o_check_cnt saturates still increments o_err_cnt (unless it is also saturated) and still pulses o_mismatch.
- Reset mid-run: the pipe is flushed and all statistics are cleared. Post-reset warm-up applies again.
- i_en toggling: bubbles travel through the pipe, so checks stay aligned with the DUT result timing.

Decomposition:
- rv32i_pkg: reuse ALUSel_e. Add constant ALU_SHAMT_W=5.
- Add alu_chk_entry_t struct {valid, op, a, b, exp} to the package for the delay pipe.
- One natural sub-module: alu_ref_model, a combinational golden function {op,a,b} -> {supported, result}. It is reusable by other benches.
- The delay pipe and statistics logic stay in scoreboard_alu.

Test Plan:
1. LATENCY=0, ADD a=0xFFFFFFFF b=0x1, DUT returns 0x0 -> no o_mismatch; o_check_cnt=1, o_err_cnt=0.
2. SRA a=0x80000000 b=0x00000024, DUT forced 0x08000000 -> expected 0xF8000000. o_mismatch pulses one cycle later; o_err_flag=1; o_first_exp=0xF8000000, o_first_got=0x08000000.
3. SLT a=0xFFFFFFFF b=0x1 -> expected 0x1; SLTU same operands -> expected 0x0. Correct DUT gives o_err_cnt=0 and o_check_cnt=2.
4. LATENCY=2, 10 enabled samples after reset, DUT delayed 2 cycles -> o_check_cnt=8 after the 10th edge, o_err_cnt=0. The same run with i_en low for 3 cycles leaves those cycles uncounted.
5. CNT_W=4: two failures (SUB then XOR) followed by 20 passes -> o_err_cnt=2; o_first_op=ALU_SUB retained; o_check_cnt saturates at 15.
6. Assert i_rst_n low mid-run with pending pipe entries -> all outputs 0 immediately (async). After release, no checks for LATENCY edges, then normal counting.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared RV32I definitions used by the ALU and its unit-level bench logic.
//   ALUSel_e         : ALU opcode selector. Encodings 10..15 are unused.
//   ALU_SHAMT_W      : number of operand-B bits that form a shift amount.
//   alu_chk_entry_t  : one slot of the scoreboard delay pipe.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } ALUSel_e;

  localparam int ALU_SHAMT_W = 5;

  // A sampled transaction travelling towards the compare point. A slot with
  // valid=0 is a bubble and carries no meaningful payload.
  typedef struct packed {
    logic        valid;
    ALUSel_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_chk_entry_t;

endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model
// Combinational golden ALU: computes the 32-bit wrap-around result of an
// RV32I ALU operation and flags whether the opcode is one it understands.
// Ports:
//   op        : ALU opcode
//   a, b      : operands (shift amount is b[4:0])
//   supported : 1 when op is a defined encoding
//   result    : golden result, 0 for unsupported opcodes
module alu_ref_model
  import rv32i_pkg::*;
(
  input  ALUSel_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        supported,
  output logic [31:0] result
);

  logic [ALU_SHAMT_W-1:0] shamt;

  assign shamt = b[ALU_SHAMT_W-1:0];

  // Golden function; any undefined encoding reports unsupported so the
  // scoreboard can treat it as a bubble.
  always_comb begin
    supported = 1'b1;
    result    = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'b0, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/scoreboard_alu.sv
// scoreboard_alu
// Bench-side checker for an ALU. Samples the operand/opcode bus, computes the
// golden result, delays it by LATENCY cycles to line up with the DUT result,
// compares, and keeps saturating pass/fail statistics plus a snapshot of the
// first failing transaction.
// Parameters:
//   LATENCY : DUT pipeline depth in cycles (0 = combinational ALU), 0..8
//   CNT_W   : width of the check and error counters
// Ports:
//   i_clk, i_rst_n            : clock (rising edge), async active-low reset
//   i_en                      : sample enable; low inserts a bubble
//   i_operand_a/b, i_alu_op   : stimulus as driven to the DUT
//   i_alu_data                : DUT result
//   o_mismatch                : registered one-cycle pulse per failed check
//   o_err_flag                : sticky failure flag
//   o_check_cnt, o_err_cnt    : saturating check / failure counters
//   o_first_op/a/b/exp/got    : first failing transaction
module scoreboard_alu
  import rv32i_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [31:0]      i_operand_a,
  input  logic [31:0]      i_operand_b,
  input  ALUSel_e          i_alu_op,
  input  logic [31:0]      i_alu_data,
  output logic             o_mismatch,
  output logic             o_err_flag,
  output logic [CNT_W-1:0] o_check_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output ALUSel_e          o_first_op,
  output logic [31:0]      o_first_a,
  output logic [31:0]      o_first_b,
  output logic [31:0]      o_first_exp,
  output logic [31:0]      o_first_got
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic           ref_supported;
  logic [31:0]    ref_result;
  alu_chk_entry_t sample_entry;
  alu_chk_entry_t cmp_entry;
  logic           cmp_fail;

  alu_ref_model u_ref (
    .op        (i_alu_op),
    .a         (i_operand_a),
    .b         (i_operand_b),
    .supported (ref_supported),
    .result    (ref_result)
  );

  // Build this cycle's pipe entry. Disabled cycles and unsupported opcodes
  // still enter the pipe, as bubbles, so later entries keep their timing.
  always_comb begin
    sample_entry.valid = i_en & ref_supported;
    sample_entry.op    = i_alu_op;
    sample_entry.a     = i_operand_a;
    sample_entry.b     = i_operand_b;
    sample_entry.exp   = ref_result;
  end

  generate
    if (LATENCY == 0) begin : g_no_pipe
      // Combinational DUT: compare against this cycle's golden value.
      always_comb cmp_entry = sample_entry;
    end else begin : g_pipe
      alu_chk_entry_t pipe_q [LATENCY];

      // Delay pipe; the last stage is aligned with the DUT result that
      // belongs to it. Reset flushes every slot to a bubble.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= sample_entry;
          for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      always_comb cmp_entry = pipe_q[LATENCY-1];
    end
  endgenerate

  assign cmp_fail = cmp_entry.valid && (cmp_entry.exp != i_alu_data);

  // Statistics. The two counters saturate independently, so a failure on the
  // edge where the check counter tops out is still counted and still pulses.
  // The first-failure snapshot loads only while the sticky flag is clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mismatch  <= 1'b0;
      o_err_flag  <= 1'b0;
      o_check_cnt <= '0;
      o_err_cnt   <= '0;
      o_first_op  <= ALU_ADD;
      o_first_a   <= '0;
      o_first_b   <= '0;
      o_first_exp <= '0;
      o_first_got <= '0;
    end else begin
      o_mismatch <= cmp_fail;
      if (cmp_entry.valid && (o_check_cnt != CNT_MAX)) begin
        o_check_cnt <= o_check_cnt + CNT_ONE;
      end
      if (cmp_fail && (o_err_cnt != CNT_MAX)) begin
        o_err_cnt <= o_err_cnt + CNT_ONE;
      end
      if (cmp_fail && !o_err_flag) begin
        o_err_flag  <= 1'b1;
        o_first_op  <= cmp_entry.op;
        o_first_a   <= cmp_entry.a;
        o_first_b   <= cmp_entry.b;
        o_first_exp <= cmp_entry.exp;
        o_first_got <= i_alu_data;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_alu.sv
// tb_scoreboard_alu
// Three scoreboards watch one stimulus stream: u_l0 (LATENCY=0), u_l2
// (LATENCY=2, fed a 2-cycle delayed DUT result) and u_sat (LATENCY=0,
// CNT_W=4). A queue-based reference tracks the expected statistics.
module tb_scoreboard_alu;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] a, b, got0, d1, d2;
  ALUSel_e     op;

  logic        l0_mis, l0_flag, l2_mis, l2_flag, sat_mis, sat_flag;
  logic [31:0] l0_chk, l0_err, l2_chk, l2_err;
  logic [3:0]  sat_chk, sat_err;
  ALUSel_e     l0_fop, l2_fop, sat_fop;
  logic [31:0] l0_fa, l0_fb, l0_fe, l0_fg;
  logic [31:0] l2_fa, l2_fb, l2_fe, l2_fg;
  logic [31:0] sat_fa, sat_fb, sat_fe, sat_fg;

  typedef struct {
    longint      chk;
    longint      err;
    bit          mis;
    bit          flag;
    ALUSel_e     fop;
    logic [31:0] fa, fb, fe, fg;
  } stat_t;

  typedef struct {
    int          due;
    int          who;
    ALUSel_e     op;
    logic [31:0] a, b, e, g;
  } pend_t;

  typedef struct {
    ALUSel_e     op;
    logic [31:0] a, b, exp;
  } vec_t;

  stat_t  m [3];
  longint lim [3];
  pend_t  pq [$];
  vec_t   vecs [14];
  int     cyc;
  int     checks;
  int     errors;

  always #5 clk = ~clk;

  // Behavioural model of a 2-cycle DUT pipeline for u_l2.
  always @(posedge clk) begin
    d1 <= got0;
    d2 <= d1;
  end

  scoreboard_alu #(.LATENCY(0), .CNT_W(32)) u_l0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_operand_a(a), .i_operand_b(b),
    .i_alu_op(op), .i_alu_data(got0), .o_mismatch(l0_mis), .o_err_flag(l0_flag),
    .o_check_cnt(l0_chk), .o_err_cnt(l0_err), .o_first_op(l0_fop), .o_first_a(l0_fa),
    .o_first_b(l0_fb), .o_first_exp(l0_fe), .o_first_got(l0_fg));

  scoreboard_alu #(.LATENCY(2), .CNT_W(32)) u_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_operand_a(a), .i_operand_b(b),
    .i_alu_op(op), .i_alu_data(d2), .o_mismatch(l2_mis), .o_err_flag(l2_flag),
    .o_check_cnt(l2_chk), .o_err_cnt(l2_err), .o_first_op(l2_fop), .o_first_a(l2_fa),
    .o_first_b(l2_fb), .o_first_exp(l2_fe), .o_first_got(l2_fg));

  scoreboard_alu #(.LATENCY(0), .CNT_W(4)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_operand_a(a), .i_operand_b(b),
    .i_alu_op(op), .i_alu_data(got0), .o_mismatch(sat_mis), .o_err_flag(sat_flag),
    .o_check_cnt(sat_chk), .o_err_cnt(sat_err), .o_first_op(sat_fop), .o_first_a(sat_fa),
    .o_first_b(sat_fb), .o_first_exp(sat_fe), .o_first_got(sat_fg));

  // Golden ALU from arithmetic: shifts become multiply/divide by 2**shamt,
  // arithmetic right shift is a floor division of the signed value.
  function automatic bit ref_op(input ALUSel_e o, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] r);
    longint ux, uy, sx, sy, p;
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    p  = 1;
    repeat (int'(y % 32)) p = p * 2;
    r      = '0;
    ref_op = 1'b1;
    case (o)
      ALU_ADD:  r = 32'(ux + uy);
      ALU_SUB:  r = 32'(ux - uy);
      ALU_SLL:  r = 32'(ux * p);
      ALU_SRL:  r = 32'(ux / p);
      ALU_SRA:  r = 32'((sx >= 0) ? (sx / p) : -((-sx + p - 1) / p));
      ALU_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (ux < uy) ? 32'd1 : 32'd0;
      ALU_XOR:  r = x ^ y;
      ALU_OR:   r = x | y;
      ALU_AND:  r = x & y;
      default:  ref_op = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkInst(input string nm, input int k, input logic mis, input logic flag,
                           input logic [31:0] chk, input logic [31:0] err, input ALUSel_e fop,
                           input logic [31:0] fa, input logic [31:0] fb,
                           input logic [31:0] fe, input logic [31:0] fg);
    cmp({nm, ".mismatch"}, 32'(mis), 32'(m[k].mis));
    cmp({nm, ".err_flag"}, 32'(flag), 32'(m[k].flag));
    cmp({nm, ".check_cnt"}, chk, 32'(m[k].chk));
    cmp({nm, ".err_cnt"}, err, 32'(m[k].err));
    cmp({nm, ".first_op"}, 32'(fop), 32'(m[k].fop));
    cmp({nm, ".first_a"}, fa, m[k].fa);
    cmp({nm, ".first_b"}, fb, m[k].fb);
    cmp({nm, ".first_exp"}, fe, m[k].fe);
    cmp({nm, ".first_got"}, fg, m[k].fg);
  endtask

  task automatic checkOutput();
    checkInst("l0", 0, l0_mis, l0_flag, l0_chk, l0_err, l0_fop, l0_fa, l0_fb, l0_fe, l0_fg);
    checkInst("l2", 1, l2_mis, l2_flag, l2_chk, l2_err, l2_fop, l2_fa, l2_fb, l2_fe, l2_fg);
    checkInst("sat", 2, sat_mis, sat_flag, 32'(sat_chk), 32'(sat_err), sat_fop,
              sat_fa, sat_fb, sat_fe, sat_fg);
  endtask

  function automatic void clearModel();
    for (int k = 0; k < 3; k++) begin
      m[k].chk  = 0;
      m[k].err  = 0;
      m[k].mis  = 1'b0;
      m[k].flag = 1'b0;
      m[k].fop  = ALU_ADD;
      m[k].fa   = '0;
      m[k].fb   = '0;
      m[k].fe   = '0;
      m[k].fg   = '0;
    end
    pq.delete();
  endfunction

  function automatic void retire(input pend_t p);
    int k;
    k = p.who;
    if (m[k].chk < lim[k]) m[k].chk++;
    if (p.e != p.g) begin
      m[k].mis = 1'b1;
      if (m[k].err < lim[k]) m[k].err++;
      if (!m[k].flag) begin
        m[k].flag = 1'b1;
        m[k].fop  = p.op;
        m[k].fa   = p.a;
        m[k].fb   = p.b;
        m[k].fe   = p.e;
        m[k].fg   = p.g;
      end
    end
  endfunction

  // Drive one cycle of stimulus (called at a negedge), advance the model on
  // the rising edge, compare just after it, and return at the next negedge.
  task automatic applyStimulus(input bit e, input ALUSel_e o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] g);
    logic [31:0] r;
    bit          sup;
    pend_t       keep [$];
    sup  = ref_op(o, x, y, r);
    en   = e;
    op   = o;
    a    = x;
    b    = y;
    got0 = g;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) m[k].mis = 1'b0;
    if (e && sup) begin
      pq.push_back('{due: cyc,     who: 0, op: o, a: x, b: y, e: r, g: g});
      pq.push_back('{due: cyc + 2, who: 1, op: o, a: x, b: y, e: r, g: g});
      pq.push_back('{due: cyc,     who: 2, op: o, a: x, b: y, e: r, g: g});
    end
    foreach (pq[i]) begin
      if (pq[i].due == cyc) retire(pq[i]);
      else keep.push_back(pq[i]);
    end
    pq = keep;
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic stepGood(input bit e, input ALUSel_e o, input logic [31:0] x,
                          input logic [31:0] y);
    logic [31:0] r;
    void'(ref_op(o, x, y, r));
    applyStimulus(e, o, x, y, r);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic resetDut();
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    clearModel();
    #1;
    checkOutput();
    cmp("reset.l2_check_cnt", l2_chk, 32'd0);
    cmp("reset.l0_err_flag", 32'(l0_flag), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] x, y, r, g;
    ALUSel_e     o;
    bit          e;

    checks = 0;
    errors = 0;
    cyc    = 0;
    lim[0] = 64'hFFFF_FFFF;
    lim[1] = 64'hFFFF_FFFF;
    lim[2] = 64'd15;
    rst_n  = 1'b0;
    en     = 1'b0;
    op     = ALU_ADD;
    a      = '0;
    b      = '0;
    got0   = '0;
    clearModel();

    vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[3]  = '{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
    vecs[4]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[5]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
    vecs[6]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    vecs[7]  = '{ALU_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
    vecs[8]  = '{ALU_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
    vecs[9]  = '{ALU_SRA,  32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000};
    vecs[10] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[11] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[12] = '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[13] = '{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};

    @(negedge clk);
    resetDut();

    // Golden-function table: DUT returns the tabulated value, never a failure.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      cmp("table.mismatch", 32'(l0_mis), 32'd0);
      cmp("table.check_cnt", l0_chk, 32'(i + 1));
    end
    cmp("table.err_cnt", l0_err, 32'd0);

    // Forced wrong SRA result, then a correct transaction.
    resetDut();
    applyStimulus(1'b1, ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    cmp("sra.mismatch", 32'(l0_mis), 32'd1);
    cmp("sra.err_flag", 32'(l0_flag), 32'd1);
    cmp("sra.first_exp", l0_fe, 32'hF800_0000);
    cmp("sra.first_got", l0_fg, 32'h0800_0000);
    stepGood(1'b1, ALU_ADD, 32'd1, 32'd2);
    cmp("sra.pulse_end", 32'(l0_mis), 32'd0);
    cmp("sra.flag_held", 32'(l0_flag), 32'd1);
    stepGood(1'b0, ALU_ADD, 32'd0, 32'd0);

    // Narrow counters: two failures, then enough passes to saturate.
    resetDut();
    applyStimulus(1'b1, ALU_SUB, 32'd10, 32'd3, 32'd0);
    applyStimulus(1'b1, ALU_XOR, 32'hF0, 32'h0F, 32'd0);
    for (int i = 0; i < 20; i++) stepGood(1'b1, ALU_ADD, 32'(i), 32'(3 * i));
    cmp("sat.err_cnt", 32'(sat_err), 32'd2);
    cmp("sat.check_cnt", 32'(sat_chk), 32'd15);
    cmp("sat.first_op", 32'(sat_fop), 32'(ALU_SUB));
    cmp("sat.wide_check_cnt", l0_chk, 32'd22);

    // Two-cycle latency warm-up and bubble alignment.
    resetDut();
    for (int i = 0; i < 10; i++) stepGood(1'b1, ALU_OR, 32'(i), 32'h100 << i);
    cmp("lat2.check_cnt_10", l2_chk, 32'd8);
    cmp("lat2.err_cnt", l2_err, 32'd0);
    for (int i = 0; i < 3; i++) stepGood(1'b0, ALU_ADD, 32'd7, 32'd7);
    cmp("lat2.after_bubbles", l2_chk, 32'd10);
    stepGood(1'b1, ALU_SLL, 32'h3, 32'd4);
    stepGood(1'b1, ALU_SRA, 32'hF000_0000, 32'd8);
    for (int i = 0; i < 3; i++) stepGood(1'b0, ALU_ADD, 32'd0, 32'd0);
    cmp("lat2.drained", l2_chk, 32'd12);
    stepGood(1'b1, ALU_SLL, 32'd1, 32'd1);
    stepGood(1'b1, ALUSel_e'(4'd13), 32'd1, 32'd1);
    cmp("unsupported.not_counted", l0_chk, 32'd13);

    // Reset with entries still in flight, then warm-up again.
    stepGood(1'b1, ALU_ADD, 32'd5, 32'd6);
    stepGood(1'b1, ALU_ADD, 32'd7, 32'd8);
    resetDut();
    stepGood(1'b1, ALU_AND, 32'hFF, 32'h0F);
    stepGood(1'b1, ALU_AND, 32'hFF, 32'hF0);
    cmp("rst.warmup", l2_chk, 32'd0);
    stepGood(1'b1, ALU_AND, 32'hFF, 32'h3C);
    cmp("rst.first_check", l2_chk, 32'd1);

    // Randomized traffic with occasional corrupted results and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        resetDut();
      end else begin
        e = ($urandom_range(0, 3) != 0);
        o = ALUSel_e'(4'($urandom_range(0, 15)));
        x = pick();
        y = pick();
        void'(ref_op(o, x, y, r));
        g = ($urandom_range(0, 7) == 0) ? (r ^ ($urandom | 32'd1)) : r;
        applyStimulus(e, o, x, y, g);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
